axi_sram_responder: RTL and testbench

AXI_SRAM_RESPONDER -- requirements
Module: axi_sram_responder

---
 rtl/axi_sram_responder.sv | 289 ++++++++++++++++++++++++++++
 tb/tb_axi_sram_responder.sv | 380 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_sram_responder.sv
// AXI4 slave backed by a byte-writable on-chip SRAM. Independent read and
// write burst engines, one outstanding burst each, INCR bursts only.
module axi_sram_responder #(
    parameter int ADDR_WD   = 32,
    parameter int DATA_WD   = 32,
    parameter int MEM_WORDS = 256
) (
    input  logic                   clk,
    input  logic                   rst,

    input  logic                   M_AXI_ARVALID,
    input  logic [ADDR_WD-1:0]     M_AXI_ARADDR,
    input  logic [7:0]             M_AXI_ARLEN,
    input  logic [2:0]             M_AXI_ARSIZE,
    input  logic [1:0]             M_AXI_ARBURST,
    output logic                   M_AXI_ARREADY,

    output logic                   M_AXI_RVALID,
    output logic [DATA_WD-1:0]     M_AXI_RDATA,
    output logic [1:0]             M_AXI_RRESP,
    output logic                   M_AXI_RLAST,
    input  logic                   M_AXI_RREADY,

    input  logic                   M_AXI_AWVALID,
    input  logic [ADDR_WD-1:0]     M_AXI_AWADDR,
    input  logic [7:0]             M_AXI_AWLEN,
    input  logic [2:0]             M_AXI_AWSIZE,
    input  logic [1:0]             M_AXI_AWBURST,
    output logic                   M_AXI_AWREADY,

    input  logic                   M_AXI_WVALID,
    input  logic [DATA_WD-1:0]     M_AXI_WDATA,
    input  logic [DATA_WD/8-1:0]   M_AXI_WSTRB,
    input  logic                   M_AXI_WLAST,
    output logic                   M_AXI_WREADY,

    output logic                   M_AXI_BVALID,
    output logic [1:0]             M_AXI_BRESP,
    input  logic                   M_AXI_BREADY
);

    localparam int STRB_WD = DATA_WD / 8;
    localparam int LG_STRB = (STRB_WD > 1) ? $clog2(STRB_WD) : 0;
    localparam int IDX_WD  = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] BURST_INCR  = 2'b01;

    typedef enum logic {
        R_IDLE = 1'b0,
        R_DATA = 1'b1
    } r_state_t;

    typedef enum logic [1:0] {
        W_IDLE = 2'b00,
        W_DATA = 2'b01,
        W_RESP = 2'b10
    } w_state_t;

    function automatic logic [IDX_WD-1:0] word_idx(input logic [ADDR_WD-1:0] addr);
        word_idx = addr[LG_STRB +: IDX_WD];
    endfunction

    // Align down to the transfer size, then step by one transfer.
    function automatic logic [ADDR_WD-1:0] next_addr(input logic [ADDR_WD-1:0] addr,
                                                     input logic [2:0]         size);
        logic [ADDR_WD-1:0] step;
        step      = ADDR_WD'(1) << size;
        next_addr = (addr & ~(step - ADDR_WD'(1))) + step;
    endfunction

    function automatic logic burst_bad(input logic [1:0] burst, input logic [2:0] size);
        burst_bad = (burst != BURST_INCR) || (size > 3'(LG_STRB));
    endfunction

    // A lane belongs to the beat when it shares every offset bit above the size.
    function automatic logic [STRB_WD-1:0] lane_window(input logic [ADDR_WD-1:0] addr,
                                                       input logic [2:0]         size);
        logic [ADDR_WD-1:0] off;
        off         = addr & (ADDR_WD'(STRB_WD) - ADDR_WD'(1));
        lane_window = {STRB_WD{1'b0}};
        for (int i = 0; i < STRB_WD; i++) begin
            lane_window[i] = (((ADDR_WD'(i) ^ off) >> size) == {ADDR_WD{1'b0}});
        end
    endfunction

    logic [DATA_WD-1:0] r_mem [MEM_WORDS];

    r_state_t           r_rstate;
    logic [ADDR_WD-1:0] r_raddr;
    logic [2:0]         r_rsize;
    logic [7:0]         r_rlen;
    logic [7:0]         r_rbeat;
    logic               r_rerr;
    logic               r_arready;
    logic               r_rvalid;
    logic               r_rlast;
    logic [DATA_WD-1:0] r_rdata;
    logic [1:0]         r_rresp;

    w_state_t           r_wstate;
    logic [ADDR_WD-1:0] r_waddr;
    logic [2:0]         r_wsize;
    logic [7:0]         r_wlen;
    logic [7:0]         r_wbeat;
    logic               r_werr;
    logic               r_wlast_err;
    logic               r_awready;
    logic               r_wready;
    logic               r_bvalid;
    logic [1:0]         r_bresp;

    logic               w_ar_hs;
    logic               w_r_hs;
    logic               w_ar_bad;
    logic [ADDR_WD-1:0] w_rnext_addr;
    logic               w_aw_hs;
    logic               w_w_hs;
    logic               w_b_hs;
    logic               w_w_last_beat;
    logic               w_wlast_bad;
    logic [ADDR_WD-1:0] w_wnext_addr;
    logic               w_mem_we;
    logic [STRB_WD-1:0] w_mem_lanes;
    logic [IDX_WD-1:0]  w_mem_idx;

    assign w_ar_hs       = r_arready && M_AXI_ARVALID;
    assign w_r_hs        = r_rvalid && M_AXI_RREADY;
    assign w_ar_bad      = burst_bad(M_AXI_ARBURST, M_AXI_ARSIZE);
    assign w_rnext_addr  = next_addr(r_raddr, r_rsize);

    assign w_aw_hs       = r_awready && M_AXI_AWVALID;
    assign w_w_hs        = r_wready && M_AXI_WVALID;
    assign w_b_hs        = r_bvalid && M_AXI_BREADY;
    assign w_w_last_beat = (r_wbeat == r_wlen);
    assign w_wlast_bad   = (M_AXI_WLAST != w_w_last_beat);
    assign w_wnext_addr  = next_addr(r_waddr, r_wsize);

    // Read engine: fetches each beat into the registered RDATA on the handshake before it.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rstate  <= R_IDLE;
            r_raddr   <= {ADDR_WD{1'b0}};
            r_rsize   <= 3'd0;
            r_rlen    <= 8'd0;
            r_rbeat   <= 8'd0;
            r_rerr    <= 1'b0;
            r_arready <= 1'b0;
            r_rvalid  <= 1'b0;
            r_rlast   <= 1'b0;
            r_rdata   <= {DATA_WD{1'b0}};
            r_rresp   <= RESP_OKAY;
        end else begin
            case (r_rstate)
                R_IDLE: begin
                    r_arready <= 1'b1;
                    if (w_ar_hs) begin
                        r_arready <= 1'b0;
                        r_raddr   <= M_AXI_ARADDR;
                        r_rsize   <= M_AXI_ARSIZE;
                        r_rlen    <= M_AXI_ARLEN;
                        r_rbeat   <= 8'd0;
                        r_rerr    <= w_ar_bad;
                        r_rvalid  <= 1'b1;
                        r_rlast   <= (M_AXI_ARLEN == 8'd0);
                        r_rdata   <= w_ar_bad ? {DATA_WD{1'b0}} : r_mem[word_idx(M_AXI_ARADDR)];
                        r_rresp   <= w_ar_bad ? RESP_SLVERR : RESP_OKAY;
                        r_rstate  <= R_DATA;
                    end
                end
                R_DATA: begin
                    if (w_r_hs) begin
                        if (r_rlast) begin
                            r_rvalid  <= 1'b0;
                            r_rlast   <= 1'b0;
                            r_rresp   <= RESP_OKAY;
                            r_arready <= 1'b1;
                            r_rstate  <= R_IDLE;
                        end else begin
                            r_raddr <= w_rnext_addr;
                            r_rbeat <= r_rbeat + 8'd1;
                            r_rlast <= ((r_rbeat + 8'd1) == r_rlen);
                            r_rdata <= r_rerr ? {DATA_WD{1'b0}} : r_mem[word_idx(w_rnext_addr)];
                        end
                    end
                end
                default: begin
                    r_rstate <= R_IDLE;
                end
            endcase
        end
    end

    // Write engine: length follows AWLEN; a misplaced WLAST only poisons BRESP.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wstate    <= W_IDLE;
            r_waddr     <= {ADDR_WD{1'b0}};
            r_wsize     <= 3'd0;
            r_wlen      <= 8'd0;
            r_wbeat     <= 8'd0;
            r_werr      <= 1'b0;
            r_wlast_err <= 1'b0;
            r_awready   <= 1'b0;
            r_wready    <= 1'b0;
            r_bvalid    <= 1'b0;
            r_bresp     <= RESP_OKAY;
        end else begin
            case (r_wstate)
                W_IDLE: begin
                    r_awready <= 1'b1;
                    if (w_aw_hs) begin
                        r_awready   <= 1'b0;
                        r_waddr     <= M_AXI_AWADDR;
                        r_wsize     <= M_AXI_AWSIZE;
                        r_wlen      <= M_AXI_AWLEN;
                        r_wbeat     <= 8'd0;
                        r_werr      <= burst_bad(M_AXI_AWBURST, M_AXI_AWSIZE);
                        r_wlast_err <= 1'b0;
                        r_wready    <= 1'b1;
                        r_wstate    <= W_DATA;
                    end
                end
                W_DATA: begin
                    if (w_w_hs) begin
                        if (w_wlast_bad) begin
                            r_wlast_err <= 1'b1;
                        end
                        if (w_w_last_beat) begin
                            r_wready <= 1'b0;
                            r_bvalid <= 1'b1;
                            r_bresp  <= (r_werr || r_wlast_err || w_wlast_bad) ? RESP_SLVERR : RESP_OKAY;
                            r_wstate <= W_RESP;
                        end else begin
                            r_waddr <= w_wnext_addr;
                            r_wbeat <= r_wbeat + 8'd1;
                        end
                    end
                end
                W_RESP: begin
                    if (w_b_hs) begin
                        r_bvalid  <= 1'b0;
                        r_bresp   <= RESP_OKAY;
                        r_awready <= 1'b1;
                        r_wstate  <= W_IDLE;
                    end
                end
                default: begin
                    r_wstate <= W_IDLE;
                end
            endcase
        end
    end

    // Byte-lane write enables for the current W beat.
    always_comb begin
        w_mem_we    = 1'b0;
        w_mem_lanes = {STRB_WD{1'b0}};
        w_mem_idx   = word_idx(r_waddr);
        if (w_w_hs && !r_werr && !rst) begin
            w_mem_we    = 1'b1;
            w_mem_lanes = M_AXI_WSTRB & lane_window(r_waddr, r_wsize);
        end else begin
            w_mem_we    = 1'b0;
            w_mem_lanes = {STRB_WD{1'b0}};
        end
    end

    // Storage array; deliberately not touched by reset.
    always_ff @(posedge clk) begin
        for (int i = 0; i < STRB_WD; i++) begin
            if (w_mem_we && w_mem_lanes[i]) begin
                r_mem[w_mem_idx][8*i +: 8] <= M_AXI_WDATA[8*i +: 8];
            end
        end
    end

    assign M_AXI_ARREADY = r_arready;
    assign M_AXI_RVALID  = r_rvalid;
    assign M_AXI_RDATA   = r_rdata;
    assign M_AXI_RRESP   = r_rresp;
    assign M_AXI_RLAST   = r_rlast;
    assign M_AXI_AWREADY = r_awready;
    assign M_AXI_WREADY  = r_wready;
    assign M_AXI_BVALID  = r_bvalid;
    assign M_AXI_BRESP   = r_bresp;

endmodule

// File: tb/tb_axi_sram_responder.sv
// Directed bench for axi_sram_responder: stimulus tasks push expected R beats
// and B responses into queues; a negedge monitor pops and compares them.
module tb_axi_sram_responder;

    localparam logic [1:0] OKAY   = 2'b00;
    localparam logic [1:0] SLVERR = 2'b10;
    localparam logic [1:0] INCR   = 2'b01;
    localparam logic [1:0] FIXED  = 2'b00;
    localparam logic [1:0] WRAP   = 2'b10;

    logic        clk;
    logic        rst;
    logic        M_AXI_ARVALID;
    logic [31:0] M_AXI_ARADDR;
    logic [7:0]  M_AXI_ARLEN;
    logic [2:0]  M_AXI_ARSIZE;
    logic [1:0]  M_AXI_ARBURST;
    logic        M_AXI_ARREADY;
    logic        M_AXI_RVALID;
    logic [31:0] M_AXI_RDATA;
    logic [1:0]  M_AXI_RRESP;
    logic        M_AXI_RLAST;
    logic        M_AXI_RREADY;
    logic        M_AXI_AWVALID;
    logic [31:0] M_AXI_AWADDR;
    logic [7:0]  M_AXI_AWLEN;
    logic [2:0]  M_AXI_AWSIZE;
    logic [1:0]  M_AXI_AWBURST;
    logic        M_AXI_AWREADY;
    logic        M_AXI_WVALID;
    logic [31:0] M_AXI_WDATA;
    logic [3:0]  M_AXI_WSTRB;
    logic        M_AXI_WLAST;
    logic        M_AXI_WREADY;
    logic        M_AXI_BVALID;
    logic [1:0]  M_AXI_BRESP;
    logic        M_AXI_BREADY;

    typedef struct {
        logic [31:0] data;
        logic [1:0]  resp;
        logic        last;
    } rexp_t;

    rexp_t       exp_r[$];
    logic [1:0]  exp_b[$];
    int          checks   = 0;
    int          failures = 0;

    rexp_t       mon_e;
    logic [1:0]  mon_b;
    logic        mon_stalled = 1'b0;
    logic [31:0] mon_held_data;
    logic [1:0]  mon_held_resp;
    logic        mon_held_last;

    axi_sram_responder #(
        .ADDR_WD   (32),
        .DATA_WD   (32),
        .MEM_WORDS (256)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .M_AXI_ARVALID (M_AXI_ARVALID),
        .M_AXI_ARADDR  (M_AXI_ARADDR),
        .M_AXI_ARLEN   (M_AXI_ARLEN),
        .M_AXI_ARSIZE  (M_AXI_ARSIZE),
        .M_AXI_ARBURST (M_AXI_ARBURST),
        .M_AXI_ARREADY (M_AXI_ARREADY),
        .M_AXI_RVALID  (M_AXI_RVALID),
        .M_AXI_RDATA   (M_AXI_RDATA),
        .M_AXI_RRESP   (M_AXI_RRESP),
        .M_AXI_RLAST   (M_AXI_RLAST),
        .M_AXI_RREADY  (M_AXI_RREADY),
        .M_AXI_AWVALID (M_AXI_AWVALID),
        .M_AXI_AWADDR  (M_AXI_AWADDR),
        .M_AXI_AWLEN   (M_AXI_AWLEN),
        .M_AXI_AWSIZE  (M_AXI_AWSIZE),
        .M_AXI_AWBURST (M_AXI_AWBURST),
        .M_AXI_AWREADY (M_AXI_AWREADY),
        .M_AXI_WVALID  (M_AXI_WVALID),
        .M_AXI_WDATA   (M_AXI_WDATA),
        .M_AXI_WSTRB   (M_AXI_WSTRB),
        .M_AXI_WLAST   (M_AXI_WLAST),
        .M_AXI_WREADY  (M_AXI_WREADY),
        .M_AXI_BVALID  (M_AXI_BVALID),
        .M_AXI_BRESP   (M_AXI_BRESP),
        .M_AXI_BREADY  (M_AXI_BREADY)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=0x%08h required=0x%08h", name, act, req);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_r(input logic [31:0] data, input logic [1:0] resp, input logic last);
        rexp_t e;
        e.data = data;
        e.resp = resp;
        e.last = last;
        exp_r.push_back(e);
    endtask

    task automatic issue_ar(input logic [31:0] addr, input logic [7:0] len,
                            input logic [2:0] size, input logic [1:0] burst);
        bit ok = 1'b0;
        M_AXI_ARADDR  = addr;
        M_AXI_ARLEN   = len;
        M_AXI_ARSIZE  = size;
        M_AXI_ARBURST = burst;
        M_AXI_ARVALID = 1'b1;
        for (int k = 0; k < 50 && !ok; k++) begin
            @(negedge clk);
            if (M_AXI_ARREADY) ok = 1'b1;
            tick();
        end
        M_AXI_ARVALID = 1'b0;
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL ar_handshake actual=timeout required=ARREADY");
        end else begin
            check("rvalid_latency", 32'(M_AXI_RVALID), 32'd1);
            check("arready_drop", 32'(M_AXI_ARREADY), 32'd0);
        end
    endtask

    task automatic issue_aw(input logic [31:0] addr, input logic [7:0] len,
                            input logic [2:0] size, input logic [1:0] burst);
        bit ok = 1'b0;
        M_AXI_AWADDR  = addr;
        M_AXI_AWLEN   = len;
        M_AXI_AWSIZE  = size;
        M_AXI_AWBURST = burst;
        M_AXI_AWVALID = 1'b1;
        for (int k = 0; k < 50 && !ok; k++) begin
            @(negedge clk);
            if (M_AXI_AWREADY) ok = 1'b1;
            tick();
        end
        M_AXI_AWVALID = 1'b0;
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL aw_handshake actual=timeout required=AWREADY");
        end else begin
            check("wready_up", 32'(M_AXI_WREADY), 32'd1);
        end
    endtask

    task automatic send_w(input logic [31:0] data, input logic [3:0] strb, input logic last);
        bit ok = 1'b0;
        M_AXI_WDATA  = data;
        M_AXI_WSTRB  = strb;
        M_AXI_WLAST  = last;
        M_AXI_WVALID = 1'b1;
        for (int k = 0; k < 50 && !ok; k++) begin
            @(negedge clk);
            if (M_AXI_WREADY) ok = 1'b1;
            tick();
        end
        M_AXI_WVALID = 1'b0;
        M_AXI_WLAST  = 1'b0;
        if (!ok) begin
            checks++;
            failures++;
            $display("FAIL w_handshake actual=timeout required=WREADY");
        end
    endtask

    task automatic wait_idle(input string name);
        int k = 0;
        while ((exp_r.size() != 0 || exp_b.size() != 0) && k < 400) begin
            @(negedge clk);
            k++;
        end
        checks++;
        if (exp_r.size() != 0 || exp_b.size() != 0) begin
            failures++;
            $display("FAIL %s_drain actual=%0d_r/%0d_b_pending required=0", name, exp_r.size(), exp_b.size());
            exp_r.delete();
            exp_b.delete();
        end
        tick();
        tick();
    endtask

    task automatic do_write(input logic [31:0] addr, input logic [7:0] len, input logic [2:0] size,
                            input logic [1:0] burst, input logic [31:0] base, input bit inc,
                            input logic [3:0] strb, input int wlast_at, input logic [1:0] bresp);
        exp_b.push_back(bresp);
        issue_aw(addr, len, size, burst);
        for (int i = 0; i <= int'(len); i++) begin
            send_w(inc ? base + 32'(i) : base, strb, i == wlast_at);
        end
        wait_idle("write");
    endtask

    task automatic do_read(input logic [31:0] addr, input logic [7:0] len, input logic [2:0] size,
                           input logic [1:0] burst);
        issue_ar(addr, len, size, burst);
        wait_idle("read");
    endtask

    // Monitor: compares every R/B handshake against the queues, plus stall stability.
    initial begin
        forever begin
            @(negedge clk);
            if (rst) begin
                mon_stalled = 1'b0;
            end else begin
                if (M_AXI_RVALID) begin
                    check("arready_low_in_burst", 32'(M_AXI_ARREADY), 32'd0);
                    if (mon_stalled) begin
                        check("rdata_hold", M_AXI_RDATA, mon_held_data);
                        check("rresp_hold", 32'(M_AXI_RRESP), 32'(mon_held_resp));
                        check("rlast_hold", 32'(M_AXI_RLAST), 32'(mon_held_last));
                    end
                end
                if (M_AXI_RVALID && M_AXI_RREADY) begin
                    checks++;
                    if (exp_r.size() == 0) begin
                        failures++;
                        $display("FAIL unexpected_r actual=0x%08h required=no_beat", M_AXI_RDATA);
                    end else begin
                        mon_e = exp_r.pop_front();
                        check("rdata", M_AXI_RDATA, mon_e.data);
                        check("rresp", 32'(M_AXI_RRESP), 32'(mon_e.resp));
                        check("rlast", 32'(M_AXI_RLAST), 32'(mon_e.last));
                    end
                end
                mon_stalled   = M_AXI_RVALID && !M_AXI_RREADY;
                mon_held_data = M_AXI_RDATA;
                mon_held_resp = M_AXI_RRESP;
                mon_held_last = M_AXI_RLAST;
                if (M_AXI_BVALID && M_AXI_BREADY) begin
                    checks++;
                    if (exp_b.size() == 0) begin
                        failures++;
                        $display("FAIL unexpected_b actual=%0d required=no_response", M_AXI_BRESP);
                    end else begin
                        mon_b = exp_b.pop_front();
                        check("bresp", 32'(M_AXI_BRESP), 32'(mon_b));
                    end
                end
            end
        end
    end

    initial begin
        rst = 1'b1;
        M_AXI_ARVALID = 1'b0; M_AXI_ARADDR = 32'h0; M_AXI_ARLEN = 8'h0;
        M_AXI_ARSIZE  = 3'd0; M_AXI_ARBURST = 2'b00;
        M_AXI_AWVALID = 1'b0; M_AXI_AWADDR = 32'h0; M_AXI_AWLEN = 8'h0;
        M_AXI_AWSIZE  = 3'd0; M_AXI_AWBURST = 2'b00;
        M_AXI_WVALID  = 1'b0; M_AXI_WDATA = 32'h0; M_AXI_WSTRB = 4'h0; M_AXI_WLAST = 1'b0;
        M_AXI_RREADY  = 1'b1;
        M_AXI_BREADY  = 1'b1;
        repeat (3) tick();

        check("rst_arready", 32'(M_AXI_ARREADY), 32'd0);
        check("rst_awready", 32'(M_AXI_AWREADY), 32'd0);
        check("rst_rvalid",  32'(M_AXI_RVALID),  32'd0);
        check("rst_rlast",   32'(M_AXI_RLAST),   32'd0);
        check("rst_wready",  32'(M_AXI_WREADY),  32'd0);
        check("rst_bvalid",  32'(M_AXI_BVALID),  32'd0);
        check("rst_rdata",   M_AXI_RDATA,        32'h0);
        check("rst_rresp",   32'(M_AXI_RRESP),   32'd0);
        check("rst_bresp",   32'(M_AXI_BRESP),   32'd0);
        rst = 1'b0;
        tick();
        check("arready_after_rst", 32'(M_AXI_ARREADY), 32'd1);
        check("awready_after_rst", 32'(M_AXI_AWREADY), 32'd1);

        // Basic INCR burst write then read back.
        do_write(32'h10, 8'd3, 3'd2, INCR, 32'hA0, 1'b1, 4'hF, 3, OKAY);
        push_r(32'hA0, OKAY, 1'b0);
        push_r(32'hA1, OKAY, 1'b0);
        push_r(32'hA2, OKAY, 1'b0);
        push_r(32'hA3, OKAY, 1'b1);
        do_read(32'h10, 8'd3, 3'd2, INCR);

        // Narrow byte burst over a zeroed word.
        do_write(32'h20, 8'd0, 3'd2, INCR, 32'h0, 1'b0, 4'hF, 0, OKAY);
        do_write(32'h21, 8'd2, 3'd0, INCR, 32'hFFFF_FFFF, 1'b0, 4'hF, 2, OKAY);
        push_r(32'hFFFF_FF00, OKAY, 1'b1);
        do_read(32'h20, 8'd0, 3'd2, INCR);

        // Sparse strobe.
        do_write(32'h30, 8'd0, 3'd2, INCR, 32'hFFFF_FFFF, 1'b0, 4'hF, 0, OKAY);
        do_write(32'h30, 8'd0, 3'd2, INCR, 32'h1122_3344, 1'b0, 4'b0101, 0, OKAY);
        push_r(32'hFF22_FF44, OKAY, 1'b1);
        do_read(32'h30, 8'd0, 3'd2, INCR);

        // 16-beat read with RREADY toggling every cycle.
        do_write(32'h100, 8'd15, 3'd2, INCR, 32'hB0, 1'b1, 4'hF, 15, OKAY);
        for (int i = 0; i < 16; i++) push_r(32'hB0 + 32'(i), OKAY, i == 15);
        issue_ar(32'h100, 8'd15, 3'd2, INCR);
        for (int k = 0; k < 100 && exp_r.size() != 0; k++) begin
            M_AXI_RREADY = ~M_AXI_RREADY;
            tick();
        end
        M_AXI_RREADY = 1'b1;
        wait_idle("read_stall");

        // Error bursts: FIXED and oversize reads, misplaced/missing WLAST, WRAP write.
        push_r(32'h0, SLVERR, 1'b0);
        push_r(32'h0, SLVERR, 1'b1);
        do_read(32'h10, 8'd1, 3'd2, FIXED);
        push_r(32'h0, SLVERR, 1'b1);
        do_read(32'h10, 8'd0, 3'd3, INCR);
        do_write(32'h200, 8'd1, 3'd2, INCR, 32'hC0, 1'b1, 4'hF, 0, SLVERR);
        do_write(32'h34, 8'd0, 3'd2, INCR, 32'h77, 1'b0, 4'hF, -1, SLVERR);
        do_write(32'h10, 8'd0, 3'd2, WRAP, 32'hDEAD_0000, 1'b0, 4'hF, 0, SLVERR);
        push_r(32'hA0, OKAY, 1'b1);
        do_read(32'h10, 8'd0, 3'd2, INCR);

        // Index wraps modulo MEM_WORDS.
        do_write(32'h404, 8'd0, 3'd2, INCR, 32'h5A5A_1234, 1'b0, 4'hF, 0, OKAY);
        push_r(32'h5A5A_1234, OKAY, 1'b1);
        do_read(32'h4, 8'd0, 3'd2, INCR);

        // Reset during write beat 1 and read beat 2.
        issue_aw(32'h40, 8'd3, 3'd2, INCR);
        send_w(32'h99, 4'hF, 1'b0);
        M_AXI_RREADY = 1'b0;
        push_r(32'hA0, OKAY, 1'b0);
        push_r(32'hA1, OKAY, 1'b0);
        issue_ar(32'h10, 8'd7, 3'd2, INCR);
        M_AXI_RREADY = 1'b1;
        tick();
        tick();
        M_AXI_RREADY = 1'b0;
        rst = 1'b1;
        tick();
        check("midrst_rvalid",  32'(M_AXI_RVALID),  32'd0);
        check("midrst_bvalid",  32'(M_AXI_BVALID),  32'd0);
        check("midrst_wready",  32'(M_AXI_WREADY),  32'd0);
        check("midrst_arready", 32'(M_AXI_ARREADY), 32'd0);
        check("midrst_awready", 32'(M_AXI_AWREADY), 32'd0);
        check("midrst_rlast",   32'(M_AXI_RLAST),   32'd0);
        check("midrst_rdata",   M_AXI_RDATA,        32'h0);
        rst = 1'b0;
        tick();
        check("post_rst_arready", 32'(M_AXI_ARREADY), 32'd1);
        check("post_rst_awready", 32'(M_AXI_AWREADY), 32'd1);
        check("post_rst_r_pending", 32'(exp_r.size()), 32'd0);
        M_AXI_RREADY = 1'b1;
        push_r(32'hA0, OKAY, 1'b0);
        push_r(32'hA1, OKAY, 1'b0);
        push_r(32'hA2, OKAY, 1'b0);
        push_r(32'hA3, OKAY, 1'b1);
        do_read(32'h10, 8'd3, 3'd2, INCR);
        push_r(32'h99, OKAY, 1'b1);
        do_read(32'h40, 8'd0, 3'd2, INCR);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
